// File: rtl/ahb_sa_subordinate_if.sv
// AHB-Lite bus bundle between a single manager and the accelerator register block.
interface ahb_sa_subordinate_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [63:0]       hwdata;
    logic [63:0]       hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output hsel, haddr, htrans, hsize, hwrite, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hwrite, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_sa_subordinate.sv
// AHB-Lite register block for the systolic-array accelerator: weight/input/bias
// staging, control pulses, result shadow and sticky status, with 2-cycle ERROR.
module ahb_sa_subordinate #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    ahb_sa_subordinate_if.slave bus,
    output logic [63:0] weight_reg,
    output logic [63:0] input_reg,
    output logic [63:0] bias_vec,
    output logic [1:0]  activation_mode,
    output logic        load_weights,
    output logic        start_inference,
    output logic        load_weights_en,
    output logic        load_inputs_en,
    input  logic        controller_busy,
    input  logic        data_ready,
    input  logic        weights_done,
    input  logic        inputs_done,
    input  logic        occupancy_err,
    input  logic [63:0] output_reg
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR2
    } state_t;

    typedef enum logic [2:0] {
        R_WEIGHT  = 3'd0,
        R_INPUT   = 3'd1,
        R_BIAS    = 3'd2,
        R_RESULT  = 3'd3,
        R_CONTROL = 3'd4,
        R_STATUS  = 3'd5,
        R_RSVD6   = 3'd6,
        R_RSVD7   = 3'd7
    } reg_sel_t;

    state_t      state;
    reg_sel_t    dp_sel;
    logic        dp_write;
    logic        dp_addr_err;
    logic [63:0] result_q;
    logic        done_sticky;
    logic        occ_sticky;

    logic [ADDR_W-1:0] haddr_full;
    logic [5:0]        ap_off;
    reg_sel_t          ap_sel;
    logic              unused_bits;

    assign haddr_full  = bus.haddr;
    assign ap_off      = haddr_full[5:0];
    assign ap_sel      = reg_sel_t'(ap_off[5:3]);
    assign unused_bits = ^{haddr_full[ADDR_W-1:6], bus.htrans[0]};

    // Errors knowable from the address phase alone are registered with it.
    logic ap_err;
    always_comb begin
        ap_err = 1'b0;
        if (bus.hsize != 3'd3)     ap_err = 1'b1;
        if (ap_off[2:0] != 3'd0)   ap_err = 1'b1;
        case (ap_sel)
            R_WEIGHT, R_INPUT:  if (!bus.hwrite) ap_err = 1'b1;
            R_RESULT, R_STATUS: if (bus.hwrite)  ap_err = 1'b1;
            R_BIAS, R_CONTROL:  begin end
            default:            ap_err = 1'b1;
        endcase
    end

    // Busy and control-bit errors depend on hwdata, so hready/hresp must be
    // combinational in the data phase to keep OKAY transfers zero-wait.
    logic dp_err;
    always_comb begin
        dp_err = dp_addr_err;
        if (dp_write) begin
            case (dp_sel)
                R_WEIGHT, R_INPUT: if (controller_busy) dp_err = 1'b1;
                R_CONTROL: begin
                    if ((bus.hwdata[0] | bus.hwdata[1]) & controller_busy) dp_err = 1'b1;
                    if (bus.hwdata[0] & bus.hwdata[1])                      dp_err = 1'b1;
                end
                default: begin end
            endcase
        end
    end

    logic in_data, err_cyc1, commit, accept, hready_c, status_clr;
    assign in_data    = (state == ST_DATA);
    assign err_cyc1   = in_data & dp_err;
    assign commit     = in_data & ~dp_err;
    assign hready_c   = ~err_cyc1;
    assign accept     = hready_c & bus.hsel & bus.htrans[1];
    assign status_clr = commit & ~dp_write & (dp_sel == R_STATUS);

    assign bus.hready = hready_c;
    assign bus.hresp  = err_cyc1 | (state == ST_ERR2);

    logic [63:0] rdata;
    always_comb begin
        rdata = '0;
        if (commit & ~dp_write) begin
            case (dp_sel)
                R_BIAS:    rdata = bias_vec;
                R_RESULT:  rdata = result_q;
                R_CONTROL: rdata = {60'd0, activation_mode, 2'b00};
                R_STATUS:  rdata = {59'd0, occ_sticky, done_sticky, weights_done,
                                    inputs_done, controller_busy};
                default:   rdata = '0;
            endcase
        end
    end
    assign bus.hrdata = rdata;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= ST_IDLE;
            dp_sel          <= R_WEIGHT;
            dp_write        <= 1'b0;
            dp_addr_err     <= 1'b0;
            result_q        <= '0;
            done_sticky     <= 1'b0;
            occ_sticky      <= 1'b0;
            weight_reg      <= '0;
            input_reg       <= '0;
            bias_vec        <= '0;
            activation_mode <= '0;
            load_weights    <= 1'b0;
            start_inference <= 1'b0;
            load_weights_en <= 1'b0;
            load_inputs_en  <= 1'b0;
        end else begin
            load_weights    <= 1'b0;
            start_inference <= 1'b0;
            load_weights_en <= 1'b0;
            load_inputs_en  <= 1'b0;

            if (data_ready) result_q <= output_reg;
            // A set event in the same cycle as a STATUS-read clear wins.
            done_sticky <= data_ready    | (done_sticky & ~status_clr);
            occ_sticky  <= occupancy_err | (occ_sticky  & ~status_clr);

            if (accept)        state <= ST_DATA;
            else if (err_cyc1) state <= ST_ERR2;
            else               state <= ST_IDLE;

            if (accept) begin
                dp_sel      <= ap_sel;
                dp_write    <= bus.hwrite;
                dp_addr_err <= ap_err;
            end

            if (commit & dp_write) begin
                case (dp_sel)
                    R_WEIGHT: begin
                        weight_reg      <= bus.hwdata;
                        load_weights_en <= 1'b1;
                    end
                    R_INPUT: begin
                        input_reg      <= bus.hwdata;
                        load_inputs_en <= 1'b1;
                    end
                    R_BIAS: bias_vec <= bus.hwdata;
                    R_CONTROL: begin
                        activation_mode <= bus.hwdata[3:2];
                        load_weights    <= bus.hwdata[0];
                        start_inference <= bus.hwdata[1];
                    end
                    default: begin end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_sa_subordinate.sv
// Directed self-checking bench for ahb_sa_subordinate.
module tb_ahb_sa_subordinate;

    logic        clk;
    logic        n_rst;
    logic [63:0] weight_reg, input_reg, bias_vec, output_reg;
    logic [1:0]  activation_mode;
    logic        load_weights, start_inference, load_weights_en, load_inputs_en;
    logic        controller_busy, data_ready, weights_done, inputs_done, occupancy_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [63:0] BIAS_V = 64'hA5A5_5A5A_0123_4567;

    ahb_sa_subordinate_if #(.ADDR_W(8)) bus ();

    ahb_sa_subordinate #(.ADDR_W(8)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .bus             (bus),
        .weight_reg      (weight_reg),
        .input_reg       (input_reg),
        .bias_vec        (bias_vec),
        .activation_mode (activation_mode),
        .load_weights    (load_weights),
        .start_inference (start_inference),
        .load_weights_en (load_weights_en),
        .load_inputs_en  (load_inputs_en),
        .controller_busy (controller_busy),
        .data_ready      (data_ready),
        .weights_done    (weights_done),
        .inputs_done     (inputs_done),
        .occupancy_err   (occupancy_err),
        .output_reg      (output_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [7:0] a, input logic w, input logic [2:0] sz);
        bus.hsel   = 1'b1;
        bus.htrans = 2'd2;
        bus.haddr  = a;
        bus.hwrite = w;
        bus.hsize  = sz;
    endtask

    task automatic idle_bus();
        bus.hsel   = 1'b0;
        bus.htrans = 2'd0;
        bus.hwrite = 1'b0;
        bus.haddr  = '0;
        bus.hsize  = 3'd3;
    endtask

    initial begin
        n_rst = 1'b0;
        controller_busy = 0; data_ready = 0; weights_done = 0; inputs_done = 0;
        occupancy_err = 0; output_reg = '0;
        idle_bus();
        bus.hwdata = '0;

        // reset state
        #3;
        chk("rst_hready", 64'(bus.hready), 64'd1);
        chk("rst_hresp",  64'(bus.hresp),  64'd0);
        chk("rst_hrdata", bus.hrdata, 64'd0);
        chk("rst_weight", weight_reg, 64'd0);
        chk("rst_mode",   64'(activation_mode), 64'd0);
        @(posedge clk); #1;

        // WEIGHT write, first transfer right after reset release
        n_rst = 1'b1;
        addr_phase(8'h00, 1'b1, 3'd3);
        tick();
        bus.hwdata = 64'h0102_0304_0506_0708;
        idle_bus();
        @(negedge clk);
        chk("w_hready", 64'(bus.hready), 64'd1);
        chk("w_hresp",  64'(bus.hresp),  64'd0);
        chk("w_hrdata", bus.hrdata, 64'd0);
        tick();
        @(negedge clk);
        chk("w_weight", weight_reg, 64'h0102_0304_0506_0708);
        chk("w_lwen_hi", 64'(load_weights_en), 64'd1);
        tick();
        @(negedge clk);
        chk("w_lwen_lo", 64'(load_weights_en), 64'd0);

        // CONTROL write 0x6 then back-to-back CONTROL read
        tick();
        addr_phase(8'h20, 1'b1, 3'd3);
        tick();
        bus.hwdata = 64'h6;
        addr_phase(8'h20, 1'b0, 3'd3);
        @(negedge clk);
        chk("cw_hresp", 64'(bus.hresp), 64'd0);
        tick();
        idle_bus();
        bus.hwdata = '0;
        @(negedge clk);
        chk("cr_hrdata", bus.hrdata, 64'h4);
        chk("cr_hresp",  64'(bus.hresp), 64'd0);
        chk("c_start_hi", 64'(start_inference), 64'd1);
        chk("c_lw_lo",    64'(load_weights), 64'd0);
        chk("c_mode",     64'(activation_mode), 64'd1);
        tick();
        @(negedge clk);
        chk("c_start_lo", 64'(start_inference), 64'd0);

        // BIAS write then read of the same address: forwarded value
        tick();
        addr_phase(8'h10, 1'b1, 3'd3);
        tick();
        bus.hwdata = BIAS_V;
        addr_phase(8'h10, 1'b0, 3'd3);
        tick();
        idle_bus();
        bus.hwdata = '0;
        @(negedge clk);
        chk("bias_fwd", bus.hrdata, BIAS_V);
        chk("bias_reg", bias_vec, BIAS_V);

        // INPUT write while controller busy -> two-cycle ERROR
        tick();
        controller_busy = 1'b1;
        addr_phase(8'h08, 1'b1, 3'd3);
        tick();
        bus.hwdata = 64'h1111_2222_3333_4444;
        idle_bus();
        @(negedge clk);
        chk("busy_e1_hready", 64'(bus.hready), 64'd0);
        chk("busy_e1_hresp",  64'(bus.hresp),  64'd1);
        tick();
        @(negedge clk);
        chk("busy_e2_hready", 64'(bus.hready), 64'd1);
        chk("busy_e2_hresp",  64'(bus.hresp),  64'd1);
        chk("busy_e2_lien",   64'(load_inputs_en), 64'd0);
        tick();
        @(negedge clk);
        chk("busy_after_hresp", 64'(bus.hresp), 64'd0);
        chk("busy_input_reg",   input_reg, 64'd0);
        chk("busy_lien",        64'(load_inputs_en), 64'd0);
        controller_busy = 1'b0;

        // CONTROL write with both start bits -> ERROR, mode untouched
        tick();
        addr_phase(8'h20, 1'b1, 3'd3);
        tick();
        bus.hwdata = 64'h3;
        idle_bus();
        @(negedge clk);
        chk("both_e1_hresp", 64'(bus.hresp), 64'd1);
        tick();
        @(negedge clk);
        chk("both_lw",    64'(load_weights), 64'd0);
        chk("both_start", 64'(start_inference), 64'd0);
        tick();
        @(negedge clk);
        chk("both_mode",  64'(activation_mode), 64'd1);
        chk("both_start2", 64'(start_inference), 64'd0);

        // hsize != 3 on BIAS write -> ERROR, bias unchanged
        addr_phase(8'h10, 1'b1, 3'd2);
        tick();
        bus.hwdata = 64'h77;
        idle_bus();
        @(negedge clk);
        chk("size_e1_hready", 64'(bus.hready), 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("size_bias", bias_vec, BIAS_V);

        // misaligned read -> ERROR with zero read data
        addr_phase(8'h14, 1'b0, 3'd3);
        tick();
        idle_bus();
        @(negedge clk);
        chk("misal_hresp",  64'(bus.hresp), 64'd1);
        chk("misal_hrdata", bus.hrdata, 64'd0);
        tick();
        tick();

        // RESULT capture, then RESULT/STATUS/STATUS reads
        weights_done = 1'b1;
        output_reg = 64'hDEAD_BEEF;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        output_reg = '0;
        addr_phase(8'h18, 1'b0, 3'd3);
        tick();
        addr_phase(8'h28, 1'b0, 3'd3);
        @(negedge clk);
        chk("res_read", bus.hrdata, 64'hDEAD_BEEF);
        tick();
        addr_phase(8'h28, 1'b0, 3'd3);
        @(negedge clk);
        chk("stat1", bus.hrdata, 64'hC);
        tick();
        idle_bus();
        @(negedge clk);
        chk("stat2", bus.hrdata, 64'h4);
        tick();

        // occupancy sticky, and set-wins when data_ready meets a clear
        occupancy_err = 1'b1;
        tick();
        occupancy_err = 1'b0;
        addr_phase(8'h28, 1'b0, 3'd3);
        tick();
        data_ready = 1'b1;
        output_reg = 64'h55;
        addr_phase(8'h28, 1'b0, 3'd3);
        @(negedge clk);
        chk("stat_occ", bus.hrdata, 64'h14);
        tick();
        data_ready = 1'b0;
        idle_bus();
        @(negedge clk);
        chk("stat_setwins", bus.hrdata, 64'hC);
        tick();

        // unmapped read 0x30, then BIAS read with no gap
        addr_phase(8'h30, 1'b0, 3'd3);
        tick();
        addr_phase(8'h10, 1'b0, 3'd3);
        @(negedge clk);
        chk("unm_e1_hready", 64'(bus.hready), 64'd0);
        chk("unm_e1_hresp",  64'(bus.hresp),  64'd1);
        tick();
        @(negedge clk);
        chk("unm_e2_hready", 64'(bus.hready), 64'd1);
        chk("unm_e2_hresp",  64'(bus.hresp),  64'd1);
        chk("unm_e2_hrdata", bus.hrdata, 64'd0);
        tick();
        idle_bus();
        @(negedge clk);
        chk("unm_next_data", bus.hrdata, BIAS_V);
        chk("unm_next_hresp", 64'(bus.hresp), 64'd0);
        tick();

        // WEIGHT read errors; a write shown only during ERROR cycle 1 is ignored
        addr_phase(8'h00, 1'b0, 3'd3);
        tick();
        addr_phase(8'h10, 1'b1, 3'd3);
        bus.hwdata = '1;
        @(negedge clk);
        chk("rw_e1_hresp", 64'(bus.hresp), 64'd1);
        tick();
        idle_bus();
        tick();
        @(negedge clk);
        chk("rw_ignored_hresp", 64'(bus.hresp), 64'd0);
        chk("rw_ignored_bias",  bias_vec, BIAS_V);
        bus.hwdata = '0;

        // reset asserted mid write data phase
        tick();
        addr_phase(8'h00, 1'b1, 3'd3);
        tick();
        bus.hwdata = 64'hCAFE_F00D_0000_0001;
        idle_bus();
        #2;
        n_rst = 1'b0;
        #1;
        chk("mrst_hready", 64'(bus.hready), 64'd1);
        chk("mrst_hresp",  64'(bus.hresp),  64'd0);
        chk("mrst_hrdata", bus.hrdata, 64'd0);
        chk("mrst_weight", weight_reg, 64'd0);
        chk("mrst_bias",   bias_vec, 64'd0);
        chk("mrst_mode",   64'(activation_mode), 64'd0);
        tick();
        n_rst = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("mrst_after_weight", weight_reg, 64'd0);
        chk("mrst_after_lwen",   64'(load_weights_en), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_sa_subordinate.md
AHB_SA_SUBORDINATE -- requirements
Module: ahb_sa_subordinate

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning width of the HADDR bits decoded.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have AHB-Lite inputs: hsel 1, haddr ADDR_W, htrans 2, hsize 3, hwrite 1, hwdata 64.
REQ-005 SHALL have AHB-Lite outputs: hrdata 64, hready 1, hresp 1.
REQ-006 SHALL have peripheral-side outputs, all registered:
- weight_reg, input_reg, bias_vec: 64 bits each.
- activation_mode: 2 bits.
- load_weights, start_inference, load_weights_en, load_inputs_en: 1 bit each.
REQ-007 SHALL have peripheral-side inputs: controller_busy, data_ready, weights_done, inputs_done, occupancy_err (1 bit each); output_reg (64 bits).

Function
REQ-008 SHALL decode the register map on haddr[5:0]:
- 0x00 WEIGHT: write-only.
- 0x08 INPUT: write-only.
- 0x10 BIAS: read/write.
- 0x18 RESULT: read-only.
- 0x20 CONTROL: read/write. bit0 load_weights, bit1 start_inference, bits[3:2] activation_mode.
- 0x28 STATUS: read-only; read clears the sticky bits.
REQ-009 SHALL accept a transfer only when hsel=1 and htrans is NONSEQ(2) or SEQ(3); IDLE and BUSY transfers SHALL get an OKAY response with no side effects.
REQ-010 SHALL capture haddr and hwrite in the address phase, then commit the write from hwdata in the following data-phase cycle.
REQ-011 SHALL return read data on hrdata during the data phase, with hready=1 (zero wait states) for every OKAY transfer.
REQ-012 SHALL forward data on a read that immediately follows a write to the same address, returning the newly written value.
REQ-013 A committed WEIGHT write SHALL update weight_reg and pulse load_weights_en high for exactly one cycle; a committed INPUT write SHALL do the same with input_reg and load_inputs_en.
REQ-014 A CONTROL write with bit0=1 SHALL pulse load_weights for one cycle; a CONTROL write with bit1=1 SHALL pulse start_inference for one cycle.
REQ-015 Bits[3:2] of a CONTROL write SHALL persist as activation_mode; CONTROL reads SHALL return activation_mode in bits[3:2] and zeros in bits 0 and 1.
REQ-016 SHALL capture output_reg into a RESULT shadow register on each cycle where data_ready=1; RESULT reads SHALL return that shadow register.
REQ-017 STATUS SHALL read as {59'b0, occ_sticky, done_sticky, weights_done, inputs_done, controller_busy}:
- done_sticky sets on data_ready=1.
- occ_sticky sets on occupancy_err=1.
- A STATUS read clears both sticky bits in its data phase.
- If a set event coincides with the clear, set wins.
REQ-018 SHALL issue a two-cycle ERROR response and leave all state unchanged for any of the following:
- an unmapped address (0x30 to 0x3F, or a non-8-byte-aligned address);
- a write to RESULT or STATUS;
- a read of WEIGHT or INPUT;
- hsize not equal to 3 (64-bit);
- a WEIGHT, INPUT or CONTROL start write while controller_busy=1.
REQ-019 The ERROR response SHALL be:
- cycle 1: hready=0, hresp=1;
- cycle 2: hready=1, hresp=1.
REQ-020 SHALL ignore a new address phase presented during ERROR cycle 1, and accept the new address phase presented in ERROR cycle 2.
REQ-021 SHALL drive hrdata to 0 for write transfers and for errored transfers.
REQ-022 SHALL suppress all pulse outputs when a write errors.
REQ-023 SHALL never assert load_weights and start_inference in the same cycle; a CONTROL write with both bits set SHALL error.

Reset
REQ-024 SHALL, while n_rst=0, asynchronously force:
- all data registers, the RESULT shadow and both sticky bits to 0;
- activation_mode to 0 and all pulse outputs to 0;
- hready=1, hresp=0, hrdata=0;
- any pending data phase or error sequence discarded.
REQ-025 The first transfer accepted SHALL be an address phase in the first rising edge after n_rst deasserts.

Verification
REQ-026 Write 0x00 with 0x0102030405060708, controller_busy=0 -> weight_reg=0x0102030405060708 one cycle after the data phase; load_weights_en high for exactly 1 cycle; hresp=0.
REQ-027 Write CONTROL 0x6 and then read CONTROL back-to-back -> start_inference pulses for 1 cycle; activation_mode=1; the read returns 0x4.
REQ-028 Write INPUT with controller_busy=1 -> hready 0 then 1 with hresp=1 for 2 cycles; input_reg unchanged; no load_inputs_en pulse.
REQ-029 data_ready=1 with output_reg=0xDEADBEEF, then read RESULT, STATUS, STATUS:
- RESULT read returns 0xDEADBEEF;
- first STATUS read has bit3=1;
- second STATUS read has bit3=0.
REQ-030 Read address 0x30, then read 0x10 with no gap -> ERROR on the 0x30 read; the 0x10 read returns bias_vec with OKAY.
REQ-031 Assert n_rst low mid-way through a write data phase -> all outputs are 0 (hready=1); no pulse occurs and no register changes after release.
